// File: rtl/envelope_avg_unit_pkg.sv
// Shared audio definitions for the envelope blocks: default sample width,
// the envelope averager state type and a saturating rectify helper.
package envelope_avg_unit_pkg;

    localparam int SAMPLE_WIDTH_DEF = 24;

    // Working width of abs_sat; callers sign-extend narrower samples into it.
    localparam int ABS_SAT_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        WAIT_OUT = 2'd2
    } env_state_t;

    // Saturating absolute value of a sign-extended sample of 'width' bits
    // (width <= 31). The most-negative value maps to 2^(width-1)-1 so the
    // result always fits in width-1 magnitude bits.
    function automatic logic [ABS_SAT_W-1:0] abs_sat(
        input logic [ABS_SAT_W-1:0] sample,
        input int unsigned          width
    );
        logic [ABS_SAT_W-1:0] lim;
        logic [ABS_SAT_W-1:0] mag;
        lim = (32'd1 << (width - 32'd1)) - 32'd1;
        mag = sample[ABS_SAT_W-1] ? (~sample + 32'd1) : sample;
        if (mag > lim) begin
            mag = lim;
        end
        return mag;
    endfunction

endpackage

// File: rtl/envelope_avg_unit_rectifier_sat.sv
// Combinational full-wave rectifier with saturation of the most-negative code.
module envelope_avg_unit_rectifier_sat
    import envelope_avg_unit_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) (
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic [SAMPLE_WIDTH-2:0] mag
);

    logic [ABS_SAT_W-1:0] sample_ext;
    logic [ABS_SAT_W-1:0] mag_full;
    logic                 unused_mag_hi;

    // Sign-extend, rectify with saturation, keep the width-1 magnitude bits.
    always_comb begin
        sample_ext    = {{(ABS_SAT_W-SAMPLE_WIDTH){sample[SAMPLE_WIDTH-1]}}, sample};
        mag_full      = abs_sat(sample_ext, SAMPLE_WIDTH);
        mag           = mag_full[SAMPLE_WIDTH-2:0];
        unused_mag_hi = ^mag_full[ABS_SAT_W-1:SAMPLE_WIDTH-1];
    end

endmodule

// File: rtl/envelope_avg_unit.sv
// Envelope averager: rectifies signed samples and block-averages
// 2^LOG2_WIN magnitudes, presenting a registered env_avg to the cutoff unit.
//
// Handshakes: a sample transfers on a rising edge where sample_valid &&
// sample_ready; a result transfers on a rising edge where env_valid &&
// env_ready. Neither side may make valid depend on ready. env_avg is held
// after its transfer because the consumer reads it continuously.
module envelope_avg_unit
    import envelope_avg_unit_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int LOG2_WIN     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic [SAMPLE_WIDTH-1:0] env_avg,
    output logic                    env_valid,
    input  logic                    env_ready,
    output env_state_t              state_dbg
);

    localparam int ACC_W = SAMPLE_WIDTH - 1 + LOG2_WIN;

    env_state_t              state;
    env_state_t              state_nxt;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        sum;
    logic [LOG2_WIN-1:0]     cnt;
    logic [SAMPLE_WIDTH-2:0] mag;
    logic [SAMPLE_WIDTH-1:0] avg_new;
    logic [SAMPLE_WIDTH-1:0] pending;
    logic                    accept;
    logic                    last;
    logic                    block_done;
    logic                    park;
    logic                    unused_sum_lo;

    envelope_avg_unit_rectifier_sat #(
        .SAMPLE_WIDTH(SAMPLE_WIDTH)
    ) u_rectifier (
        .sample(sample_in),
        .mag   (mag)
    );

    // Samples are only taken while accumulating.
    assign sample_ready = (state == ACCUM);
    assign state_dbg    = state;

    // Block arithmetic: running sum including the current sample and the
    // average it would produce if this sample closes the block.
    always_comb begin
        accept        = sample_valid && sample_ready;
        last          = accept && (cnt == {LOG2_WIN{1'b1}});
        sum           = acc + {{LOG2_WIN{1'b0}}, mag};
        avg_new       = {1'b0, sum[ACC_W-1:LOG2_WIN]};
        unused_sum_lo = ^sum[LOG2_WIN-1:0];
        // A sample accepted while enable is low is discarded, so no block closes.
        block_done    = (state == ACCUM) && enable && last;
        // Completed block while the previous result is still unconsumed.
        park          = block_done && env_valid && !env_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (park) begin
                    state_nxt = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (env_ready) begin
                    state_nxt = enable ? ACCUM : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accumulator and sample count; cleared outside ACCUM, on disable and
    // when a block closes.
    always_ff @(posedge clk) begin
        if (rst || (state != ACCUM) || !enable || last) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= sum;
            cnt <= cnt + LOG2_WIN'(1);
        end
    end

    // Output register and one-entry pending slot; a new result wins over
    // the clear caused by a same-cycle consumption.
    always_ff @(posedge clk) begin
        if (rst) begin
            env_avg   <= '0;
            env_valid <= 1'b0;
            pending   <= '0;
        end else if (park) begin
            pending <= avg_new;
        end else if (block_done) begin
            env_avg   <= avg_new;
            env_valid <= 1'b1;
        end else if ((state == WAIT_OUT) && env_ready) begin
            env_avg   <= pending;
            env_valid <= 1'b1;
        end else if (env_ready) begin
            env_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_envelope_avg_unit.sv
// Bench for envelope_avg_unit with a 4-sample window: directed cases plus a
// random stream, checked by a scoreboard fed from a plain-arithmetic model.
`timescale 1ns/1ps
module tb_envelope_avg_unit;
    import envelope_avg_unit_pkg::*;

    localparam int SW  = 24;
    localparam int LW  = 2;
    localparam int WIN = 1 << LW;
    localparam int MAG_MAX = (1 << (SW - 1)) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [SW-1:0] sample_in;
    logic          sample_valid;
    logic          sample_ready;
    logic [SW-1:0] env_avg;
    logic          env_valid;
    logic          env_ready;
    env_state_t    state_dbg;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_out    = 0;
    logic [SW-1:0] exp_q[$];
    int            win_q[$];
    bit            rand_done = 0;

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    envelope_avg_unit #(
        .SAMPLE_WIDTH(SW),
        .LOG2_WIN    (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .env_avg     (env_avg),
        .env_valid   (env_valid),
        .env_ready   (env_ready),
        .state_dbg   (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Rectified magnitude straight from the arithmetic definition.
    function automatic int ref_mag(input logic [SW-1:0] s);
        int v;
        v = int'(signed'(s));
        if (v < 0) v = -v;
        if (v > MAG_MAX) v = MAG_MAX;
        return v;
    endfunction

    // Reference model: collect accepted magnitudes, emit the floor average
    // of every full window; disable and reset drop partial windows.
    always @(negedge clk) begin
        int s;
        if (rst) begin
            win_q.delete();
            exp_q.delete();
        end else if (!enable) begin
            win_q.delete();
        end else if (sample_valid && sample_ready) begin
            win_q.push_back(ref_mag(sample_in));
            if (win_q.size() == WIN) begin
                s = 0;
                foreach (win_q[k]) s += win_q[k];
                exp_q.push_back(SW'(s / WIN));
                win_q.delete();
            end
        end
    end

    // Monitor: every consumed result must be the oldest expected one.
    always @(negedge clk) begin
        logic [SW-1:0] e;
        if (!rst && env_valid && env_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %0d, expected no result at %0t", env_avg, $time);
            end else begin
                e = exp_q.pop_front();
                check("env_avg_stream", 32'(env_avg), 32'(e));
            end
        end
    end

    // Driver tasks; all are entered and left 1 ns after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [SW-1:0] s);
        bit done;
        done = 0;
        sample_in    = s;
        sample_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = sample_ready;
            @(posedge clk);
            #1;
        end
        sample_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: sample %0d not accepted, expected acceptance within 100 cycles", s);
        end
    endtask

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        env_ready    = 1'b0;
        idle(3);

        // Reset state
        check("rst_sample_ready", 32'(sample_ready), 0);
        check("rst_env_valid", 32'(env_valid), 0);
        check("rst_env_avg", 32'(env_avg), 0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        rst       = 1'b0;
        enable    = 1'b1;
        env_ready = 1'b1;

        // Basic average: |4|,|-4|,|8|,|-8| -> 6
        send(SW'(4)); send(SW'(-4)); send(SW'(8)); send(SW'(-8));
        check("t1_env_valid", 32'(env_valid), 1);
        check("t1_env_avg", 32'(env_avg), 6);
        idle(2);

        // Most-negative input saturates
        repeat (4) send(24'h800000);
        check("t2_env_avg_sat", 32'(env_avg), 8388607);
        idle(2);

        // Overrun: two blocks with no consumption
        env_ready = 1'b0;
        send(SW'(4)); send(SW'(-4)); send(SW'(8)); send(SW'(-8));
        send(SW'(10)); send(SW'(10)); send(SW'(10)); send(SW'(-10));
        check("t3_sample_ready_low", 32'(sample_ready), 0);
        check("t3_state_wait", 32'(state_dbg), 32'(WAIT_OUT));
        check("t3_env_avg_first", 32'(env_avg), 6);
        idle(2);
        check("t3_env_valid_held", 32'(env_valid), 1);
        check("t3_sample_ready_held", 32'(sample_ready), 0);
        env_ready = 1'b1;
        idle(1);
        env_ready = 1'b0;
        check("t3_env_avg_second", 32'(env_avg), 10);
        check("t3_env_valid_second", 32'(env_valid), 1);
        check("t3_state_accum", 32'(state_dbg), 32'(ACCUM));
        check("t3_sample_ready_back", 32'(sample_ready), 1);
        env_ready = 1'b1;
        idle(1);
        check("t3_env_valid_clear", 32'(env_valid), 0);
        check("t3_env_avg_stable", 32'(env_avg), 10);

        // Enable drop discards the partial window, including the sample
        // presented in the disabling cycle
        send(SW'(50)); send(SW'(70));
        enable = 1'b0;
        send(SW'(999));
        enable = 1'b1;
        check("t4_sample_ready_idle", 32'(sample_ready), 0);
        env_ready = 1'b0;
        repeat (4) send(SW'(1));
        check("t4_env_avg", 32'(env_avg), 1);
        check("t4_env_valid", 32'(env_valid), 1);

        // Reset mid-window with a result outstanding
        repeat (3) send(SW'(100));
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t5_env_avg_rst", 32'(env_avg), 0);
        check("t5_env_valid_rst", 32'(env_valid), 0);
        check("t5_sample_ready_rst", 32'(sample_ready), 0);
        check("t5_state_rst", 32'(state_dbg), 32'(IDLE));
        env_ready = 1'b1;
        repeat (4) send(SW'(100));
        check("t5_env_avg", 32'(env_avg), 100);
        idle(2);

        // Random stream with gaps, random consumer stalls and enable drops
        fork
            begin
                for (int i = 0; i < 240; i++) begin
                    logic [SW-1:0] s;
                    if ($urandom_range(0, 15) == 0) s = 24'h800000;
                    else s = SW'($urandom);
                    if ($urandom_range(0, 39) == 0) begin
                        enable = 1'b0;
                        idle(1);
                        enable = 1'b1;
                    end
                    idle($urandom_range(0, 2));
                    send(s);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    env_ready = 1'($urandom_range(0, 1));
                    idle(1);
                end
            end
        join

        env_ready = 1'b1;
        idle(10);
        check("rand_results_drained", 32'(exp_q.size()), 0);
        check("rand_env_valid_final", 32'(env_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
